// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and data (D); data-priority with a fetch anti-starvation streak limit.
// Combinational issue in IDLE; winner locked until m_valid. Optional counters under MEM_ARB_PERF_EN.
module mem_port_arbiter #(
    parameter int NBITS        = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [NBITS-1:0] i_addr,
    output logic             i_rdy,
    output logic             i_valid,
    output logic [NBITS-1:0] i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [NBITS-1:0] d_addr,
    input  logic [NBITS-1:0] d_wdata,
    output logic             d_rdy,
    output logic             d_valid,
    output logic [NBITS-1:0] d_rdata,
    output logic             m_req,
    output logic             m_we,
    output logic [NBITS-1:0] m_addr,
    output logic [NBITS-1:0] m_wdata,
    input  logic             m_rdy,
    input  logic             m_valid,
    input  logic [NBITS-1:0] m_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] perf_i_grants,
    output logic [CNT_W-1:0] perf_d_grants,
    output logic [CNT_W-1:0] perf_conflicts
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [1:0]    state;
    logic          owner_d;
    logic [SW-1:0] streak;

    logic win_d, win_i;
    logic sel_d, sel_i, rsp;
    logic accept;

    assign win_d = d_req && !(i_req && (streak == STREAK_MAX));
    assign win_i = !win_d && i_req;

    // Reset gates everything so outputs drop asynchronously, not just at the next edge.
    always_comb begin
        sel_d = 1'b0;
        sel_i = 1'b0;
        rsp   = 1'b0;
        case (state)
            IDLE: begin
                sel_d = win_d;
                sel_i = win_i;
            end
            REQ: begin
                sel_d = owner_d;
                sel_i = !owner_d;
            end
            WAIT:    rsp = m_valid;
            default: ;
        endcase
        if (rst) begin
            sel_d = 1'b0;
            sel_i = 1'b0;
            rsp   = 1'b0;
        end
    end

    assign m_req   = sel_d | sel_i;
    assign m_we    = sel_d & d_we;
    assign m_addr  = sel_d ? d_addr : (sel_i ? i_addr : '0);
    assign m_wdata = sel_d ? d_wdata : '0;

    assign accept = m_req & m_rdy;
    assign i_rdy  = sel_i & m_rdy;
    assign d_rdy  = sel_d & m_rdy;

    assign i_valid = rsp & !owner_d;
    assign d_valid = rsp & owner_d;
    assign i_rdata = i_valid ? m_rdata : '0;
    assign d_rdata = d_valid ? m_rdata : '0;

    assign busy = (state != IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner_d <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_req) begin
                        owner_d <= sel_d;
                        state   <= m_rdy ? WAIT : REQ;
                    end
                end
                REQ: begin
                    if (m_rdy) state <= WAIT;
                end
                WAIT: begin
                    if (m_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Streak counts data wins only while fetch was actually waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (accept) begin
            if (sel_d && i_req) begin
                if (streak != STREAK_MAX) streak <= streak + 1'b1;
            end else begin
                streak <= '0;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [CNT_W-1:0] cnt_i, cnt_d, cnt_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_i <= '0;
            cnt_d <= '0;
            cnt_c <= '0;
        end else begin
            if (accept && sel_i) cnt_i <= cnt_i + 1'b1;
            if (accept && sel_d) cnt_d <= cnt_d + 1'b1;
            if (state == IDLE && i_req && d_req) cnt_c <= cnt_c + 1'b1;
        end
    end

    assign perf_i_grants  = cnt_i;
    assign perf_d_grants  = cnt_d;
    assign perf_conflicts = cnt_c;
`else
    assign perf_i_grants  = '0;
    assign perf_d_grants  = '0;
    assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter (MAX_D_STREAK=4); perf expectations follow MEM_ARB_PERF_EN.
module tb_mem_port_arbiter;

    localparam int NBITS = 32;
    localparam int CNT_W = 32;
`ifdef MEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             i_req;
    logic [NBITS-1:0] i_addr;
    logic             i_rdy, i_valid;
    logic [NBITS-1:0] i_rdata;
    logic             d_req, d_we;
    logic [NBITS-1:0] d_addr, d_wdata;
    logic             d_rdy, d_valid;
    logic [NBITS-1:0] d_rdata;
    logic             m_req, m_we;
    logic [NBITS-1:0] m_addr, m_wdata;
    logic             m_rdy, m_valid;
    logic [NBITS-1:0] m_rdata;
    logic             busy;
    logic [CNT_W-1:0] perf_i_grants, perf_d_grants, perf_conflicts;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NBITS(NBITS), .MAX_D_STREAK(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdy(d_rdy), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdy(m_rdy), .m_valid(m_valid), .m_rdata(m_rdata),
        .busy(busy),
        .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
        .perf_conflicts(perf_conflicts)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge; inputs are driven there, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int exp_seq [6] = '{2, 2, 2, 2, 1, 2};
        int g;
        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_rdy = 0; m_valid = 0; m_rdata = 0;
        tick(); settle();
        check_vec("rst_m_req", 32'(m_req), 0);
        check_vec("rst_busy", 32'(busy), 0);
        check_vec("rst_perf_c", perf_conflicts, 0);
        tick(); rst = 1'b0;

        // Single fetch, immediate accept, response two cycles later
        tick(); i_req = 1; i_addr = 32'h100; m_rdy = 1; settle();
        check_vec("f_m_req", 32'(m_req), 1);
        check_vec("f_m_addr", m_addr, 32'h100);
        check_vec("f_m_we", 32'(m_we), 0);
        check_vec("f_i_rdy", 32'(i_rdy), 1);
        check_vec("f_d_rdy", 32'(d_rdy), 0);
        tick(); i_req = 0; settle();
        check_vec("f_wait_busy", 32'(busy), 1);
        check_vec("f_wait_m_req", 32'(m_req), 0);
        tick(); m_valid = 1; m_rdata = 32'hDEADBEEF; settle();
        check_vec("f_i_valid", 32'(i_valid), 1);
        check_vec("f_i_rdata", i_rdata, 32'hDEADBEEF);
        check_vec("f_d_valid", 32'(d_valid), 0);
        tick(); m_valid = 0; settle();
        check_vec("f_idle_busy", 32'(busy), 0);
        check_vec("f_i_rdata0", i_rdata, 0);

        // Conflict: data first, fetch in first IDLE cycle after d_valid
        tick(); i_req = 1; i_addr = 32'h104; d_req = 1; d_addr = 32'h2000; settle();
        check_vec("c_m_addr", m_addr, 32'h2000);
        check_vec("c_d_rdy", 32'(d_rdy), 1);
        check_vec("c_i_rdy", 32'(i_rdy), 0);
        tick(); d_req = 0; m_valid = 1; m_rdata = 32'h55; settle();
        check_vec("c_d_valid", 32'(d_valid), 1);
        check_vec("c_d_rdata", d_rdata, 32'h55);
        check_vec("c_no_issue", 32'(m_req), 0);
        tick(); m_valid = 0; settle();
        check_vec("c_i_addr", m_addr, 32'h104);
        check_vec("c_i_rdy2", 32'(i_rdy), 1);
        check_vec("c_perf_c", perf_conflicts, PERF ? 32'd1 : 32'd0);
        tick(); i_req = 0; m_valid = 1; settle();
        check_vec("c_i_valid", 32'(i_valid), 1);
        tick(); m_valid = 0;

        // Streak limit: both held, immediate rdy/valid
        i_req = 1; d_req = 1; i_addr = 32'h200; d_addr = 32'h2100; m_rdy = 1;
        for (int k = 0; k < 6; k++) begin
            settle();
            g = d_rdy ? 2 : (i_rdy ? 1 : 0);
            check_vec($sformatf("streak_grant%0d", k), 32'(g), 32'(exp_seq[k]));
            tick(); m_valid = 1; settle();
            tick(); m_valid = 0;
        end
        i_req = 0; d_req = 0;

        // Stalled data request; late fetch request must not steal the port
        tick(); d_req = 1; d_addr = 32'h2400; m_rdy = 0; settle();
        check_vec("s_m_addr0", m_addr, 32'h2400);
        check_vec("s_d_rdy0", 32'(d_rdy), 0);
        for (int k = 1; k < 3; k++) begin
            tick(); i_req = 1; i_addr = 32'h108; m_valid = (k == 1); settle();
            check_vec($sformatf("s_m_addr%0d", k), m_addr, 32'h2400);
            check_vec($sformatf("s_i_rdy%0d", k), 32'(i_rdy), 0);
            check_vec($sformatf("s_d_valid%0d", k), 32'(d_valid), 0);
        end
        tick(); m_valid = 0; m_rdy = 1; settle();
        check_vec("s_d_rdy3", 32'(d_rdy), 1);
        check_vec("s_i_rdy3", 32'(i_rdy), 0);
        tick(); d_req = 0; m_valid = 1; settle();
        check_vec("s_d_valid", 32'(d_valid), 1);
        tick(); m_valid = 0; settle();
        check_vec("s_i_after", 32'(i_rdy), 1);
        tick(); i_req = 0; m_valid = 1; settle();
        tick(); m_valid = 0;

        // Write
        d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'h12345678; settle();
        check_vec("w_m_we", 32'(m_we), 1);
        check_vec("w_m_wdata", m_wdata, 32'h12345678);
        check_vec("w_d_rdy", 32'(d_rdy), 1);
        tick(); d_req = 0; d_we = 0; m_valid = 1; m_rdata = 0; settle();
        check_vec("w_d_valid", 32'(d_valid), 1);
        tick(); m_valid = 0; settle();
        check_vec("perf_i", perf_i_grants, PERF ? 32'd4 : 32'd0);
        check_vec("perf_d", perf_d_grants, PERF ? 32'd8 : 32'd0);
        check_vec("perf_c", perf_conflicts, PERF ? 32'd7 : 32'd0);

        // Stray m_valid in IDLE
        tick(); m_valid = 1; settle();
        check_vec("idle_mv_i", 32'(i_valid), 0);
        check_vec("idle_mv_d", 32'(d_valid), 0);
        check_vec("idle_mv_busy", 32'(busy), 0);
        tick(); m_valid = 0;

        // Reset while waiting for a response
        i_req = 1; i_addr = 32'h10C; settle();
        check_vec("r_i_rdy", 32'(i_rdy), 1);
        tick(); i_req = 0; settle();
        check_vec("r_busy_pre", 32'(busy), 1);
        rst = 1; settle();
        check_vec("r_busy", 32'(busy), 0);
        check_vec("r_m_req", 32'(m_req), 0);
        check_vec("r_perf_i", perf_i_grants, 0);
        tick(); rst = 0;
        tick(); m_valid = 1; m_rdata = 32'hA5A5A5A5; settle();
        check_vec("r_i_valid", 32'(i_valid), 0);
        check_vec("r_d_valid", 32'(d_valid), 0);
        check_vec("r_i_rdata", i_rdata, 0);
        tick(); m_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified memory port between the core's instruction-fetch requester (IFU) and data requester (MEM stage). Arbitrates per transaction and locks the winner until its response returns. Data has priority, bounded by an anti-starvation streak limit so fetch always progresses. Sits between the datapath's iproc_req/dproc_req interfaces and the single memory model/bus.

Parameters:
NBITS, 32, address/data width
MAX_D_STREAK, 4, max consecutive data grants while fetch is waiting (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  input  1  clock
rst  input  1  reset
i_req  input  1  fetch request (held until i_rdy)
i_addr  input  NBITS  fetch address
i_rdy  output  1  fetch request accepted this cycle
i_valid  output  1  fetch response valid (1-cycle pulse)
i_rdata  output  NBITS  fetch read data
d_req  input  1  data request (held until d_rdy)
d_we  input  1  data write enable
d_addr  input  NBITS  data address
d_wdata  input  NBITS  data write value
d_rdy  output  1  data request accepted this cycle
d_valid  output  1  data response/write-ack valid (1-cycle pulse)
d_rdata  output  NBITS  data read data
m_req  output  1  request to memory
m_we  output  1  write enable to memory
m_addr  output  NBITS  address to memory
m_wdata  output  NBITS  write data to memory
m_rdy  input  1  memory accepts request when m_req && m_rdy
m_valid  input  1  memory response valid
m_rdata  input  NBITS  memory read data
busy  output  1  state != IDLE
perf_i_grants  output  CNT_W  accepted fetch transactions
perf_d_grants  output  CNT_W  accepted data transactions
perf_conflicts  output  CNT_W  cycles where both requested in IDLE

Behaviour:
- Clock clk; reset rst asynchronous, active-high.
- Reset: state IDLE, owner cleared, streak counter 0, perf counters 0; all outputs 0 while no request.
- States: IDLE, REQ (owner locked, awaiting m_rdy), WAIT (accepted, awaiting m_valid). One outstanding transaction max.
- IDLE winner (combinational): d_req && !(i_req && streak==MAX_D_STREAK) -> D; else i_req -> I; else none.
- IDLE with winner: drive m_req=1 and winner's addr/we/wdata same cycle; m_rdy=1 -> WAIT, else -> REQ; owner=winner either way.
- REQ: drive owner's fields only; other requester ignored; m_rdy -> WAIT.
- WAIT: m_req=0; on m_valid, pulse owner's valid same cycle, rdata=m_rdata combinationally; -> IDLE. No new issue in that cycle (min 1 idle cycle between transactions).
- i_rdy = m_rdy && owner/winner==I in IDLE/REQ; d_rdy analogous. Never both.
- Fetch grants force m_we=0, m_wdata=0. Non-driven m_* outputs 0.
- i_rdata/d_rdata are 0 when the matching valid is low.
- Streak: on D acceptance with i_req high, streak+=1 (saturates at MAX_D_STREAK); on I acceptance, or D acceptance with i_req low, streak=0.
- m_valid in IDLE/REQ: ignored, no valid pulse, no state change.
- Requester dropping req in REQ: protocol violation; arbiter keeps issuing until accepted.
- Reset mid-transaction: immediate IDLE; in-flight response lost; later m_valid ignored.

Optional Feature:
MEM_ARB_PERF_EN: defined -> perf_i_grants/perf_d_grants increment on each accepted transaction, perf_conflicts increments on each IDLE cycle with i_req && d_req; counters wrap modulo 2^CNT_W. Undefined -> perf_* ports tied to 0, no counter flops.

Test Plan:
- IDLE, i_req=1, i_addr=0x100, m_rdy=1 -> same cycle m_req=1, m_addr=0x100, m_we=0, i_rdy=1; m_valid 2 cycles later, m_rdata=0xDEADBEEF -> i_valid=1, i_rdata=0xDEADBEEF, d_valid=0, then busy=0.
- Both request in IDLE (i_addr=0x104, d_addr=0x2000) -> data granted first (m_addr=0x2000, d_rdy=1); fetch granted in first IDLE cycle after d_valid; perf_conflicts=1 with macro.
- d_req and i_req held continuously, MAX_D_STREAK=4, immediate rdy/valid -> grant order D,D,D,D,I,D...
- m_rdy=0 for 3 cycles after D wins, i_req rises meanwhile -> m_addr stays d_addr, i_rdy=0 throughout, D accepted on 4th cycle.
- d_we=1, d_addr=0x3000, d_wdata=0x12345678 -> m_we=1, m_wdata=0x12345678, d_rdy=1; ack m_valid -> d_valid=1.
- rst asserted in WAIT -> outputs 0 asynchronously, busy=0; m_valid after release produces no valid pulse; perf counters 0.
